// File: rtl/rob_multi_pkg.sv
// Shared processor constants and reorder-buffer defaults.
// Imported by the ROB slice and its testbench.
package rob_multi_pkg;
  localparam int ARCH_BITS        = 32;
  localparam int REG_IDX_BITS     = 5;
  localparam int ROB_SLOTS        = 16;
  localparam int ROB_COMMIT_WIDTH = 2;
  localparam int ROB_WB_PORTS     = 3;
endpackage

// File: rtl/rob_multi_if.sv
// Allocation, writeback and commit bundle of the multi-commit ROB.
// master drives requests/writebacks, slave is the ROB.
interface rob_multi_if #(
  parameter int IDX_BITS     = 4,
  parameter int WB_PORTS     = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int ARCH_BITS    = 32,
  parameter int REG_IDX_BITS = 5,
  parameter int CC_BITS      = $clog2(COMMIT_WIDTH + 1)
);
  logic                             clear;
  logic                             alloc_req;
  logic                             alloc_ready;
  logic [IDX_BITS-1:0]              alloc_idx;
  logic [WB_PORTS-1:0]              wb_valid;
  logic [WB_PORTS*IDX_BITS-1:0]     wb_idx;
  logic [WB_PORTS-1:0]              wb_except;
  logic [WB_PORTS-1:0]              wb_we;
  logic [WB_PORTS*ARCH_BITS-1:0]    wb_pc;
  logic [WB_PORTS*ARCH_BITS-1:0]    wb_address;
  logic [WB_PORTS*ARCH_BITS-1:0]    wb_data;
  logic [WB_PORTS*REG_IDX_BITS-1:0] wb_dst;
  logic [COMMIT_WIDTH-1:0]          commit_we;
  logic [COMMIT_WIDTH*REG_IDX_BITS-1:0] commit_dst;
  logic [COMMIT_WIDTH*ARCH_BITS-1:0]    commit_data;
  logic [CC_BITS-1:0]               commit_count;
  logic                             except;
  logic [ARCH_BITS-1:0]             except_pc;
  logic [ARCH_BITS-1:0]             except_address;
  logic [IDX_BITS:0]                count;
  logic                             full;
  logic                             empty;

  modport master (
    output clear, alloc_req, wb_valid, wb_idx, wb_except, wb_we,
    output wb_pc, wb_address, wb_data, wb_dst,
    input  alloc_ready, alloc_idx, commit_we, commit_dst, commit_data,
    input  commit_count, except, except_pc, except_address,
    input  count, full, empty
  );

  modport slave (
    input  clear, alloc_req, wb_valid, wb_idx, wb_except, wb_we,
    input  wb_pc, wb_address, wb_data, wb_dst,
    output alloc_ready, alloc_idx, commit_we, commit_dst, commit_data,
    output commit_count, except, except_pc, except_address,
    output count, full, empty
  );
endinterface

// File: rtl/rob_multi_commit_select.sv
// In-order retire chain over the head-rotated entry bits.
// A lane retires only if every older lane retires.
module rob_commit_select #(
  parameter int CW       = 2,
  parameter int CNT_BITS = 5,
  parameter int CC_BITS  = $clog2(CW + 1)
) (
  input  logic [CW-1:0]       done,
  input  logic [CW-1:0]       exc,
  input  logic [CW-1:0]       we,
  input  logic [CNT_BITS-1:0] count,
  output logic [CW-1:0]       retire,
  output logic [CW-1:0]       commit_we,
  output logic [CC_BITS-1:0]  commit_count,
  output logic                except
);
  logic ok;

  always_comb begin
    retire       = '0;
    commit_count = '0;
    ok           = 1'b1;
    for (int j = 0; j < CW; j++) begin
      ok = ok && (CNT_BITS'(j) < count) && done[j] && !exc[j];
      retire[j] = ok;
      if (ok) commit_count = commit_count + CC_BITS'(1);
    end
  end

  assign commit_we = retire & we;
  assign except    = (count != '0) && done[0] && exc[0];
endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate, multi-port writeback,
// multi-lane in-order commit, flush on clear or head exception.
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int SLOTS        = ROB_SLOTS,
  parameter int IDX_BITS     = $clog2(SLOTS),
  parameter int WB_PORTS     = ROB_WB_PORTS,
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH,
  parameter int ARCH_BITS    = rob_multi_pkg::ARCH_BITS,
  parameter int REG_IDX_BITS = rob_multi_pkg::REG_IDX_BITS
) (
  input logic        clk,
  input logic        rst,
  rob_multi_if.slave bus
);
  localparam int CB  = IDX_BITS + 1;
  localparam int CCB = $clog2(COMMIT_WIDTH + 1);
  localparam int PB  = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
  localparam int AB  = ARCH_BITS;
  localparam int RB  = REG_IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;

  idx_t             head, tail;
  logic [CB-1:0]    cnt;
  logic [SLOTS-1:0] alloc_q, done_q, exc_q, we_q;
  logic [RB-1:0]    dst_q  [SLOTS];
  logic [AB-1:0]    data_q [SLOTS];
  logic [AB-1:0]    pc_q   [SLOTS];
  logic [AB-1:0]    addr_q [SLOTS];

  logic             full, fire, flush, exc_head;
  logic [SLOTS-1:0] wr, ret_slot, new_slot;
  logic [PB-1:0]    sel [SLOTS];
  idx_t             lane_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] l_done, l_exc, l_we, retire;
  logic [CCB-1:0]   ccount;

  assign full     = cnt == CB'(SLOTS);
  assign fire     = bus.alloc_req && !full;
  assign flush    = bus.clear || exc_head;
  assign new_slot = fire ? (SLOTS'(1) << tail) : '0;

  // Scan ports high to low so the lowest matching port wins.
  always_comb begin
    wr = '0;
    for (int s = 0; s < SLOTS; s++) begin
      sel[s] = '0;
      for (int k = WB_PORTS - 1; k >= 0; k--) begin
        if (bus.wb_valid[k] &&
            bus.wb_idx[k*IDX_BITS +: IDX_BITS] == idx_t'(s)) begin
          wr[s]  = alloc_q[s];
          sel[s] = PB'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      if (wr[s]) begin
        exc_q[s]  <= bus.wb_except[sel[s]];
        we_q[s]   <= bus.wb_we[sel[s]];
        dst_q[s]  <= bus.wb_dst[sel[s]*RB +: RB];
        data_q[s] <= bus.wb_data[sel[s]*AB +: AB];
        pc_q[s]   <= bus.wb_pc[sel[s]*AB +: AB];
        addr_q[s] <= bus.wb_address[sel[s]*AB +: AB];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      lane_idx[j] = head + idx_t'(j);
      l_done[j]   = done_q[lane_idx[j]];
      l_exc[j]    = exc_q[lane_idx[j]];
      l_we[j]     = we_q[lane_idx[j]];
    end
  end

  rob_commit_select #(
    .CW       (COMMIT_WIDTH),
    .CNT_BITS (CB),
    .CC_BITS  (CCB)
  ) u_sel (
    .done         (l_done),
    .exc          (l_exc),
    .we           (l_we),
    .count        (cnt),
    .retire       (retire),
    .commit_we    (bus.commit_we),
    .commit_count (ccount),
    .except       (exc_head)
  );

  always_comb begin
    ret_slot        = '0;
    bus.commit_dst  = '0;
    bus.commit_data = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (retire[j]) ret_slot[lane_idx[j]] = 1'b1;
      bus.commit_dst[j*RB +: RB]  = dst_q[lane_idx[j]];
      bus.commit_data[j*AB +: AB] = data_q[lane_idx[j]];
    end
  end

  // Retire clears last so a same-cycle writeback cannot revive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head    <= head + idx_t'(ccount);
      tail    <= tail + idx_t'(fire);
      cnt     <= cnt + CB'(fire) - CB'(ccount);
      alloc_q <= (alloc_q & ~ret_slot) | new_slot;
      done_q  <= (done_q | wr) & ~ret_slot & ~new_slot;
    end
  end

  assign bus.alloc_ready    = !full;
  assign bus.alloc_idx      = tail;
  assign bus.commit_count   = ccount;
  assign bus.except         = exc_head;
  assign bus.except_pc      = pc_q[head];
  assign bus.except_address = addr_q[head];
  assign bus.count          = cnt;
  assign bus.full           = full;
  assign bus.empty          = cnt == '0;
endmodule

// File: tb/tb_rob_multi.sv
// Directed scenarios plus random traffic against a
// slot-array model of the reorder buffer.
module tb_rob_multi;
  import rob_multi_pkg::*;

  localparam int SL = 16;
  localparam int IB = 4;
  localparam int WP = 3;
  localparam int CW = 2;
  localparam int AB = 32;
  localparam int RB = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rob_multi_if #(
    .IDX_BITS(IB), .WB_PORTS(WP), .COMMIT_WIDTH(CW),
    .ARCH_BITS(AB), .REG_IDX_BITS(RB)
  ) bus ();

  rob_multi #(
    .SLOTS(SL), .IDX_BITS(IB), .WB_PORTS(WP), .COMMIT_WIDTH(CW),
    .ARCH_BITS(AB), .REG_IDX_BITS(RB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit        al, dn, ex, we;
    bit [4:0]  dst;
    bit [31:0] data, pc, addr;
  } ent_t;

  ent_t m [SL];
  int   hd, tl, cn;

  function automatic void m_reset();
    for (int s = 0; s < SL; s++) begin
      m[s].al = 0;
      m[s].dn = 0;
    end
    hd = 0; tl = 0; cn = 0;
  endfunction

  function automatic bit m_except();
    return cn > 0 && m[hd].dn && m[hd].ex;
  endfunction

  function automatic int m_nret();
    int n = 0;
    while (n < CW && n < cn && m[(hd + n) % SL].dn && !m[(hd + n) % SL].ex)
      n++;
    return n;
  endfunction

  task automatic compare();
    int n = m_nret();
    ent_t e;
    check("alloc_ready", bus.alloc_ready, cn < SL);
    check("alloc_idx", bus.alloc_idx, tl);
    check("count", bus.count, cn);
    check("full", bus.full, cn == SL);
    check("empty", bus.empty, cn == 0);
    check("commit_count", bus.commit_count, n);
    check("except", bus.except, m_except());
    if (m_except()) begin
      check("except_pc", bus.except_pc, m[hd].pc);
      check("except_addr", bus.except_address, m[hd].addr);
    end
    for (int j = 0; j < CW; j++) begin
      e = m[(hd + j) % SL];
      check("commit_we", bus.commit_we[j], j < n && e.we);
      if (j < n) begin
        check("commit_dst", bus.commit_dst[j*RB +: RB], e.dst);
        check("commit_data", bus.commit_data[j*AB +: AB], e.data);
      end
    end
  endtask

  task automatic update();
    int  n = m_nret();
    bit  hit [SL];
    int  i;
    bit  fire;
    if (bus.clear || m_except()) begin
      m_reset();
      return;
    end
    for (int s = 0; s < SL; s++) hit[s] = 0;
    for (int k = 0; k < WP; k++) begin
      if (bus.wb_valid[k]) begin
        i = int'(bus.wb_idx[k*IB +: IB]);
        if (!hit[i]) begin
          hit[i] = 1;
          if (m[i].al) begin
            m[i].dn   = 1;
            m[i].ex   = bus.wb_except[k];
            m[i].we   = bus.wb_we[k];
            m[i].dst  = bus.wb_dst[k*RB +: RB];
            m[i].data = bus.wb_data[k*AB +: AB];
            m[i].pc   = bus.wb_pc[k*AB +: AB];
            m[i].addr = bus.wb_address[k*AB +: AB];
          end
        end
      end
    end
    for (int j = 0; j < n; j++) begin
      m[(hd + j) % SL].al = 0;
      m[(hd + j) % SL].dn = 0;
    end
    fire = bus.alloc_req && cn < SL;
    if (fire) begin
      m[tl].al = 1;
      m[tl].dn = 0;
      tl = (tl + 1) % SL;
    end
    cn = cn + int'(fire) - n;
    hd = (hd + n) % SL;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    bus.clear      = 0;
    bus.alloc_req  = 0;
    bus.wb_valid   = '0;
    bus.wb_idx     = '0;
    bus.wb_except  = '0;
    bus.wb_we      = '0;
    bus.wb_pc      = '0;
    bus.wb_address = '0;
    bus.wb_data    = '0;
    bus.wb_dst     = '0;
  endtask

  task automatic wb(int k, int idx, bit exc, int dst, int data, int pc);
    bus.wb_valid[k]            = 1'b1;
    bus.wb_idx[k*IB +: IB]     = IB'(idx);
    bus.wb_except[k]           = exc;
    bus.wb_we[k]               = 1'b1;
    bus.wb_dst[k*RB +: RB]     = RB'(dst);
    bus.wb_data[k*AB +: AB]    = AB'(data);
    bus.wb_pc[k*AB +: AB]      = AB'(pc);
    bus.wb_address[k*AB +: AB] = AB'(pc + 'h40);
  endtask

  task automatic flush_all();
    idle();
    bus.clear = 1;
    cycle();
    idle();
  endtask

  task automatic rand_drive();
    int idx;
    idle();
    bus.clear     = $urandom_range(0, 63) == 0;
    bus.alloc_req = $urandom_range(0, 9) < 6;
    for (int k = 0; k < WP; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (cn > 0 && $urandom_range(0, 7) != 0)
          idx = (hd + $urandom_range(0, cn - 1)) % SL;
        else
          idx = $urandom_range(0, SL - 1);
        wb(k, idx, $urandom_range(0, 19) == 0, $urandom, $urandom, $urandom);
        bus.wb_we[k] = $urandom_range(0, 1);
      end
    end
  endtask

  initial begin
    idle();
    m_reset();
    #2 rst = 1;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_idx", bus.alloc_idx, 0);
    check("rst_cc", bus.commit_count, 0);
    #5 rst = 0;
    @(posedge clk);
    #1;

    // fill and back-pressure
    bus.alloc_req = 1;
    repeat (16) cycle();
    check("fill_full", bus.full, 1);
    check("fill_ready", bus.alloc_ready, 0);
    cycle();
    check("fill_17th", bus.count, 16);
    idle();
    wb(0, 0, 0, 1, 'h11, 0);
    cycle();
    idle();
    bus.alloc_req = 1;
    cycle();
    check("free_count", bus.count, 15);
    check("wrap_idx", bus.alloc_idx, 0);
    cycle();
    check("wrap_count", bus.count, 16);
    check("wrap_tail", bus.alloc_idx, 1);

    // out-of-order writeback, wide commit
    flush_all();
    bus.alloc_req = 1;
    repeat (4) cycle();
    idle();
    for (int i = 3; i >= 0; i--) begin
      wb(0, i, 0, i + 1, 'h100 + i, 0);
      cycle();
      idle();
    end
    check("ooo_cc0", bus.commit_count, 2);
    check("ooo_dst0", bus.commit_dst[0 +: RB], 1);
    check("ooo_dst1", bus.commit_dst[RB +: RB], 2);
    cycle();
    check("ooo_cc1", bus.commit_count, 2);
    check("ooo_data1", bus.commit_data[AB +: AB], 'h103);
    cycle();

    // exception at entry 1
    flush_all();
    bus.alloc_req = 1;
    repeat (3) cycle();
    idle();
    wb(0, 0, 0, 3, 'h5, 'h10);
    wb(1, 1, 1, 4, 'h6, 'h40);
    wb(2, 2, 0, 5, 'h7, 'h50);
    cycle();
    idle();
    check("exc_cc", bus.commit_count, 1);
    check("exc_early", bus.except, 0);
    cycle();
    check("exc_flag", bus.except, 1);
    check("exc_pc", bus.except_pc, 'h40);
    check("exc_cc0", bus.commit_count, 0);
    cycle();
    check("exc_empty", bus.empty, 1);
    check("exc_tail", bus.alloc_idx, 0);

    // port conflict and stray writeback
    bus.alloc_req = 1;
    cycle();
    idle();
    wb(0, 0, 0, 7, 'hAAAA, 0);
    wb(1, 0, 0, 8, 'hBBBB, 0);
    wb(2, 0, 0, 9, 'hCCCC, 0);
    cycle();
    idle();
    check("conf_data", bus.commit_data[0 +: AB], 'hAAAA);
    check("conf_cc", bus.commit_count, 1);
    wb(0, 9, 0, 1, 'h1, 0);
    cycle();
    idle();
    check("stray_count", bus.count, 0);
    check("stray_cc", bus.commit_count, 0);

    // clear beats alloc and writeback
    bus.alloc_req = 1;
    repeat (3) cycle();
    bus.clear = 1;
    wb(0, 1, 0, 1, 'h1, 0);
    cycle();
    idle();
    check("clr_empty", bus.empty, 1);

    // wrap retire: head at 15
    bus.alloc_req = 1;
    repeat (15) cycle();
    idle();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < WP; k++) wb(k, c * WP + k, 0, k, c, 0);
      cycle();
      idle();
    end
    repeat (10) cycle();
    check("wrap_drain", bus.count, 0);
    bus.alloc_req = 1;
    repeat (2) cycle();
    idle();
    wb(0, 15, 0, 2, 'hF, 0);
    wb(1, 0, 0, 3, 'h0, 0);
    cycle();
    idle();
    check("wrap_cc", bus.commit_count, 2);
    cycle();
    check("wrap_head", bus.alloc_idx, 1);
    check("wrap_cnt", bus.count, 0);

    // random traffic
    repeat (3000) begin
      rand_drive();
      cycle();
    end
    idle();

    // async reset mid-cycle
    #2 rst = 1;
    #1;
    m_reset();
    check("arst_count", bus.count, 0);
    check("arst_idx", bus.alloc_idx, 0);
    check("arst_except", bus.except, 0);
    check("arst_cc", bus.commit_count, 0);
    check("arst_we", bus.commit_we, 0);
    #3 rst = 0;
    @(posedge clk);
    #1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer with in-order allocation, multi-port out-of-order writeback and up to COMMIT_WIDTH in-order commits per cycle. Sits between decode/issue (allocation), the execution pipes (writeback ports) and the register file/exception unit (commit). It adds what the single-head ROB lacks: a tail pointer with full/empty flow control, commit of more than one entry per cycle, and automatic flush on a committed exception.

## Interface
- SLOTS, 16: entry count; power of two, at least 2.
- IDX_BITS, $clog2(SLOTS): entry index width.
- WB_PORTS, 3: writeback port count.
- COMMIT_WIDTH, 2: maximum commits per cycle; from 1 to SLOTS.
- ARCH_BITS, 32: data/pc/address width.
- REG_IDX_BITS, 5: register index width.

Port vectors are flattened, with port/lane k at bits [k*W +: W].
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, e.g. on branch mispredict.
- alloc_req  in  1  request one entry.
- alloc_ready  out  1  equals !full.
- alloc_idx  out  IDX_BITS  equals tail; the index granted when alloc_req && alloc_ready.
- wb_valid  in  WB_PORTS  per-port writeback strobe.
- wb_idx  in  WB_PORTS*IDX_BITS  target entry.
- wb_except, wb_we  in  WB_PORTS each  exception flag and register-write enable.
- wb_pc, wb_address, wb_data  in  WB_PORTS*ARCH_BITS each.
- wb_dst  in  WB_PORTS*REG_IDX_BITS.
- commit_we  out  COMMIT_WIDTH  register-file write enable per lane.
- commit_dst  out  COMMIT_WIDTH*REG_IDX_BITS.
- commit_data  out  COMMIT_WIDTH*ARCH_BITS.
- commit_count  out  $clog2(COMMIT_WIDTH+1)  number of entries retiring this cycle.
- except  out  1  head entry is done and excepting.
- except_pc, except_address  out  ARCH_BITS each  fields of the head entry.
- count  out  IDX_BITS+1  occupied entries; full = (count==SLOTS); empty = (count==0).
- full, empty  out  1 each.

## Operation
- Circular buffer with head, tail and count registers. Per-entry state: alloc bit, done bit and payload.
- **Allocation:** when alloc_req && !full, set alloc[tail]=1 and done[tail]=0, and advance tail mod SLOTS. alloc_ready ignores same-cycle commits; there is no bypass.
- **Writeback:** a wb_valid[k] whose entry has alloc=1 writes the payload and sets done. A writeback to an unallocated entry is ignored. If two ports target the same index in one cycle, the lowest port wins.
- **Commit select (combinational):** lane j retires head+j when all of the following hold:
  - lanes 0..j-1 retire;
  - j < count;
  - done[head+j] is set;
  - except[head+j] is clear.
- commit_we[j] is the lane-retire condition AND the entry's we.
- Retired entries clear their alloc bit, and head advances by commit_count.
- **Exception:** except=1 when the head is done and excepting. In that cycle commit_count is 0 and the next edge flushes the buffer exactly as clear does. Entries behind the head never raise except.
- **Flush (clear or except):** head=tail=count=0 and all alloc/done bits cleared. A flush takes priority over same-cycle allocation and writeback.
- **count update:** next count = count + alloc_fire - commit_count. Simultaneous alloc and commit while full is legal: no allocation happens, and the commits proceed.
- A writeback and a commit of the same entry in one cycle: the commit sees the old done bit (0), so the entry retires no earlier than the next cycle.
- **Reset values:** head, tail and count are 0; alloc/done bits are 0; empty=1, full=0, alloc_ready=1, alloc_idx=0; commit_we=0, commit_count=0, except=0. Payload arrays are not reset.

## Timing
- Allocation at edge N makes the entry visible to writeback in cycle N+1.
- Writeback at edge N makes the entry eligible for commit in cycle N+1. Commit outputs are combinational from registered state.
- Minimum allocate-to-retire latency is 2 cycles.
- Commit outputs are valid throughout the cycle; state updates at the next edge.
- rst asserted mid-operation returns all state to reset values immediately, without waiting for clk.

## Structure
- Shared constants (ARCH_BITS, REG_IDX_BITS, default ROB SLOTS/COMMIT_WIDTH) live in the existing proc constants package.
- One sub-module, rob_commit_select: the combinational prefix chain that produces the lane retire mask, commit_count and except from the done/except/we bits rotated to the head.
- Payload storage, pointers and writeback decode stay in rob_multi.

## Test plan
- **Reset and idle.** Assert rst asynchronously mid-cycle -> outputs immediately at reset values, count=0, alloc_idx=0.
- **Fill and back-pressure.** Allocate 16 with SLOTS=16 -> full=1, alloc_ready=0. A 17th request does not allocate. One commit frees a slot, and allocation resumes at idx 0 (wrap).
- **Out-of-order writeback, wide commit.** Allocate 0..3 and write back 3, 2, 1, 0 on separate cycles -> nothing retires until idx 0 is done. Then commit_count=2 in two consecutive cycles with commit_dst/data in order.
- **Exception.** Entries 0..2 all done, entry 1 excepting with pc=0x40 -> cycle 1: commit_count=1 (entry 0). Cycle 2: except=1, except_pc=0x40, commit_count=0. Next cycle empty=1, tail=0.
- **Port conflicts.** Three ports write the same index in one cycle -> port 0 payload stored. A writeback to an unallocated index leaves done clear and count unchanged.
- **Clear versus allocation.** clear together with alloc_req and wb_valid -> empty next cycle. Wrap test: head at 15 with done entries 15 and 0 -> both retire in one cycle, head=1.
